// File: rtl/fi_campaign_ctrl.sv
// fi_campaign_ctrl
//   Sequences one fault-injection experiment on a target:
//   1. hold the target in reset;
//   2. let it run for a fixed number of clocks;
//   3. flip the masked state bits once, at a chosen run cycle;
//   4. compare the target's final state against a golden word.
//
// Parameters
//   WIDTH       width of the target state word
//   RUN_CYCLES  clocks the target runs per experiment
//   RST_CYCLES  clocks the target is held in reset per experiment
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start, abort        launch / cancel an experiment
//   inject_cycle        run-cycle index at which the flip is applied
//   inject_mask         bits to flip
//   golden              fault-free expected final state
//   dut_state           live target state word
//   dut_rst_n           active-low reset to the target
//   flip_en, flip_mask  one-cycle injection strobe and mask
//   run_cycle           current run-cycle index
//   busy, done          experiment in progress / one-cycle completion pulse
//   mismatch, skipped   final state differed / injection never applied
//   result              captured final target state
module fi_campaign_ctrl #(
  parameter int WIDTH      = 64,
  parameter int RUN_CYCLES = 64,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      inject_cycle,
  input  logic [WIDTH-1:0] inject_mask,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] dut_state,
  output logic             dut_rst_n,
  output logic             flip_en,
  output logic [WIDTH-1:0] flip_mask,
  output logic [15:0]      run_cycle,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic             skipped,
  output logic [WIDTH-1:0] result
);

  localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [15:0]    RUN_LAST = 16'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [RCW-1:0]   r_rst_cnt;
  logic [15:0]      r_inj_cycle;
  logic [WIDTH-1:0] r_inj_mask;
  logic [WIDTH-1:0] r_golden;

  logic [15:0] w_nxt_rc;
  logic        w_skip;

  assign w_nxt_rc = run_cycle + 16'd1;
  // Injection index past the end of the run can never match run_cycle.
  assign w_skip   = ({16'd0, r_inj_cycle} >= 32'(RUN_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rst_cnt   <= '0;
      r_inj_cycle <= '0;
      r_inj_mask  <= '0;
      r_golden    <= '0;
      dut_rst_n   <= 1'b0;
      flip_en     <= 1'b0;
      flip_mask   <= '0;
      run_cycle   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mismatch    <= 1'b0;
      skipped     <= 1'b0;
      result      <= '0;
    end else begin
      // Strobes default low every cycle.
      flip_en   <= 1'b0;
      flip_mask <= '0;
      done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          dut_rst_n <= 1'b1;
          busy      <= 1'b0;
          // start wins over a simultaneous abort here.
          if (start) begin
            r_inj_cycle <= inject_cycle;
            r_inj_mask  <= inject_mask;
            r_golden    <= golden;
            mismatch    <= 1'b0;
            skipped     <= 1'b0;
            result      <= '0;
            r_rst_cnt   <= '0;
            dut_rst_n   <= 1'b0;
            busy        <= 1'b1;
            r_state     <= S_RESET;
          end
        end
        S_RESET: begin
          if (abort) begin
            busy      <= 1'b0;
            dut_rst_n <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_rst_cnt == RST_LAST) begin
            // The flip for inject_cycle 0 must land on the first run clock.
            dut_rst_n <= 1'b1;
            run_cycle <= '0;
            if (r_inj_cycle == 16'd0) begin
              flip_en   <= 1'b1;
              flip_mask <= r_inj_mask;
            end
            r_state <= S_RUN;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            busy      <= 1'b0;
            dut_rst_n <= 1'b0;
            r_state   <= S_IDLE;
          end else if (run_cycle == RUN_LAST) begin
            r_state <= S_COMPARE;
          end else begin
            // flip_en is registered, so it is aimed at the upcoming run_cycle.
            run_cycle <= w_nxt_rc;
            if (w_nxt_rc == r_inj_cycle) begin
              flip_en   <= 1'b1;
              flip_mask <= r_inj_mask;
            end
          end
        end
        S_COMPARE: begin
          result   <= dut_state;
          mismatch <= (dut_state != r_golden);
          skipped  <= w_skip;
          done     <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fi_campaign_ctrl.md
FI_CAMPAIGN_CTRL -- requirements
Module: fi_campaign_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the width of the target state word.
REQ-002 The block SHALL have parameter RUN_CYCLES, default 64, giving the number of clocks the target runs per experiment.
REQ-003 The block SHALL have parameter RST_CYCLES, default 2, giving the number of clocks the target is held in reset per experiment.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request one experiment; sampled only in IDLE.
REQ-007 abort  input  1  cancel the running experiment.
REQ-008 inject_cycle  input  16  run-cycle index at which the fault is applied.
REQ-009 inject_mask  input  WIDTH  bits to flip in target state.
REQ-010 golden  input  WIDTH  fault-free expected final state.
REQ-011 dut_state  input  WIDTH  current target state word.
REQ-012 dut_rst_n  output  1  active-low reset to target.
REQ-013 flip_en  output  1  one-cycle injection strobe to target.
REQ-014 flip_mask  output  WIDTH  mask applied while flip_en=1, else 0.
REQ-015 run_cycle  output  16  current run-cycle index.
REQ-016 busy  output  1  experiment in progress.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 mismatch  output  1  final state differed from golden.
REQ-019 skipped  output  1  injection never applied (inject_cycle >= RUN_CYCLES).
REQ-020 result  output  WIDTH  captured final target state.

Function
REQ-021 All outputs SHALL be registered; states SHALL be IDLE, RESET, RUN, COMPARE, DONE.
REQ-022 IDLE: busy=0, dut_rst_n=1; start=1 SHALL latch inject_cycle, inject_mask, golden, clear mismatch/skipped/result, and enter RESET next cycle.
REQ-023 RESET: busy=1, dut_rst_n=0 for exactly RST_CYCLES clocks, then RUN with run_cycle=0 and dut_rst_n=1.
REQ-024 RUN: run_cycle SHALL increment by 1 each clock; on run_cycle==RUN_CYCLES-1 the next state SHALL be COMPARE.
REQ-025 flip_en SHALL be 1 for exactly the one clock in which run_cycle equals latched inject_cycle, with flip_mask = latched mask in that clock and 0 otherwise.
REQ-026 Latched inject_mask=0 SHALL still pulse flip_en with flip_mask=0.
REQ-027 Latched inject_cycle >= RUN_CYCLES SHALL produce no flip_en pulse and SHALL set skipped=1 at COMPARE.
REQ-028 COMPARE (one clock): result <= dut_state; mismatch <= (dut_state != golden); next DONE.
REQ-029 DONE (one clock): done=1, busy=1; next IDLE with busy=0.
REQ-030 result, mismatch, skipped SHALL hold until the next accepted start.
REQ-031 start while busy SHALL be ignored; start and abort together in IDLE SHALL be treated as start.
REQ-032 abort=1 in RESET or RUN SHALL go to IDLE next clock, with flip_en=0, dut_rst_n=0 in that transition clock, no done pulse, and result/mismatch/skipped left cleared; abort in COMPARE/DONE SHALL be ignored.
REQ-033 run_cycle SHALL hold its last value outside RUN and reset to 0 on entry to RUN.
REQ-034 Latency from accepted start to done SHALL be exactly RST_CYCLES+RUN_CYCLES+2 clocks.

Reset
REQ-035 rst=1 SHALL force, asynchronously: state IDLE, dut_rst_n=0, flip_en=0, flip_mask=0, run_cycle=0, busy=0, done=0, mismatch=0, skipped=0, result=0.
REQ-036 After rst deasserts, dut_rst_n SHALL go to 1 on the first clock edge in IDLE.
REQ-037 rst asserted mid-experiment SHALL abandon it without done pulse; a new start SHALL be required.

Verification
REQ-038 Default parameters, start, inject_cycle=10, mask=0x1, golden=0x40, dut_state=0x40 at end -> single flip_en at run_cycle 10, done 68 clocks after start, mismatch=0, result=0x40.
REQ-039 Same, dut_state=0x41 at end -> mismatch=1, result=0x41, done pulse width 1.
REQ-040 inject_cycle=64 -> no flip_en pulse, skipped=1, done still at 68 clocks.
REQ-041 abort at run_cycle 20 -> IDLE next clock, no done, busy=0; second start within run ignored, new start after IDLE accepted.
REQ-042 rst at run_cycle 30 -> all outputs to reset values immediately; following start runs full 68-clock experiment.
REQ-043 inject_cycle=0 and inject_cycle=63 -> flip_en at first and last RUN clock respectively.
